sparc_exu_thr_reqbuf: RTL and testbench

//  Per-thread request buffer for a shared multi-cycle EXU unit. Holds one request per thread.

---
 rtl/sparc_exu_thr_reqbuf.sv | 102 ++++++++++
 tb/tb_sparc_exu_thr_reqbuf.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sparc_exu_thr_reqbuf.sv
// Per-thread request buffer feeding a shared multi-cycle EXU unit.
// Holds one request per thread, asks an external round-robin scheduler for a grant, and keeps one op in flight.
module sparc_exu_thr_reqbuf #(
    parameter int unsigned DW = 64
) (
    input  logic            clk,
    input  logic            arst_l,
    input  logic [3:0]      thr_req_vld,
    input  logic [4*DW-1:0] thr_req_data,
    output logic [3:0]      thr_req_rdy,
    input  logic [3:0]      thr_flush,
    output logic [3:0]      req_vec,
    input  logic [3:0]      grant_vec,
    output logic            advance,
    output logic            unit_vld,
    output logic [1:0]      unit_tid,
    output logic [DW-1:0]   unit_data,
    input  logic            unit_rdy,
    input  logic            unit_done,
    output logic [3:0]      thr_done
);

    typedef enum logic [1:0] {StIdle, StIssue, StBusy} state_e;

    state_e          state_q;
    logic [1:0]      sel_tid_q;
    logic [3:0]      vld_q, vld_d;
    logic [3:0]      thr_done_q;
    logic [DW-1:0]   pay_q [4];
    logic [DW-1:0]   data_q;

    logic [3:0]      post;
    logic [3:0]      hit;
    logic [1:0]      hit_tid;
    logic [3:0]      sel_oh;
    logic [3:0]      committed;

    assign thr_req_rdy = ~vld_q;
    assign post        = thr_req_vld & ~vld_q;
    assign req_vec     = (state_q == StIdle) ? (vld_q & ~thr_flush) : 4'b0000;
    // Masking with req_vec drops the scheduler's default grant[0] when nothing is requested.
    assign hit         = grant_vec & req_vec;
    assign advance     = |hit;
    assign unit_vld    = (state_q == StIssue);
    assign unit_tid    = sel_tid_q;
    assign unit_data   = data_q;
    assign thr_done    = thr_done_q;

    always_comb begin
        hit_tid = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (hit[i]) hit_tid = 2'(i);
        end
    end

    always_comb begin
        sel_oh    = 4'b0001 << sel_tid_q;
        // Once selected, the op is committed and the owning entry can no longer be flushed.
        committed = (state_q != StIdle) ? sel_oh : 4'b0000;
        vld_d     = vld_q & ~(thr_flush & ~committed);
        if (state_q == StIssue && unit_rdy) vld_d = vld_d & ~sel_oh;
        vld_d     = vld_d | post;
    end

    always_ff @(posedge clk or negedge arst_l) begin
        if (!arst_l) begin
            state_q    <= StIdle;
            sel_tid_q  <= 2'd0;
            vld_q      <= 4'b0000;
            thr_done_q <= 4'b0000;
        end else begin
            vld_q      <= vld_d;
            thr_done_q <= 4'b0000;
            unique case (state_q)
                StIdle: begin
                    if (advance) begin
                        sel_tid_q <= hit_tid;
                        state_q   <= StIssue;
                    end
                end
                StIssue: begin
                    if (unit_rdy) state_q <= StBusy;
                end
                StBusy: begin
                    if (unit_done) begin
                        thr_done_q <= sel_oh;
                        state_q    <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (post[i]) pay_q[i] <= thr_req_data[i*DW +: DW];
        end
        if (state_q == StIdle && advance) data_q <= pay_q[hit_tid];
    end

endmodule

// File: tb/tb_sparc_exu_thr_reqbuf.sv
// Directed bench for sparc_exu_thr_reqbuf with a behavioural 4-thread round-robin scheduler.
module tb_sparc_exu_thr_reqbuf;

    localparam int unsigned DW = 64;

    logic            clk = 1'b0;
    logic            arst_l;
    logic [3:0]      thr_req_vld;
    logic [4*DW-1:0] thr_req_data;
    logic [3:0]      thr_req_rdy;
    logic [3:0]      thr_flush;
    logic [3:0]      req_vec;
    logic [3:0]      grant_vec;
    logic            advance;
    logic            unit_vld;
    logic [1:0]      unit_tid;
    logic [DW-1:0]   unit_data;
    logic            unit_rdy;
    logic            unit_done;
    logic [3:0]      thr_done;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    sparc_exu_thr_reqbuf #(.DW(DW)) dut (
        .clk          (clk),
        .arst_l       (arst_l),
        .thr_req_vld  (thr_req_vld),
        .thr_req_data (thr_req_data),
        .thr_req_rdy  (thr_req_rdy),
        .thr_flush    (thr_flush),
        .req_vec      (req_vec),
        .grant_vec    (grant_vec),
        .advance      (advance),
        .unit_vld     (unit_vld),
        .unit_tid     (unit_tid),
        .unit_data    (unit_data),
        .unit_rdy     (unit_rdy),
        .unit_done    (unit_done),
        .thr_done     (thr_done)
    );

    // Round-robin scheduler: search from the park pointer, grant[0] when nothing is requested.
    logic [1:0] ptr;
    logic [1:0] gidx;
    logic [1:0] idx;
    logic       found;

    always_comb begin
        grant_vec = 4'b0001;
        gidx      = 2'd0;
        idx       = 2'd0;
        found     = 1'b0;
        for (int k = 0; k < 4; k++) begin
            idx = ptr + 2'(k);
            if (!found && req_vec[idx]) begin
                found     = 1'b1;
                gidx      = idx;
                grant_vec = 4'b0001 << idx;
            end
        end
    end

    always_ff @(posedge clk or negedge arst_l) begin
        if (!arst_l) ptr <= 2'd0;
        else if (advance) ptr <= gidx + 2'd1;
    end

    function automatic logic [DW-1:0] pay(input int t);
        return {16'hA5A5, 16'(t), 32'h0F0F_0000 + 32'(t)};
    endfunction

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        step;
        arst_l      = 1'b0;
        thr_req_vld = 4'b0000;
        thr_flush   = 4'b0000;
        unit_rdy    = 1'b0;
        unit_done   = 1'b0;
        #2;
        arst_l      = 1'b1;
    endtask

    task automatic test_reset;
        step;
        arst_l = 1'b0;
        #1;
        checks++; if (thr_req_rdy !== 4'hf) begin errors++; $display("FAIL reset rdy: got %b want 1111", thr_req_rdy); end
        checks++; if (thr_done !== 4'h0) begin errors++; $display("FAIL reset thr_done: got %b want 0000", thr_done); end
        checks++; if (unit_vld !== 1'b0) begin errors++; $display("FAIL reset unit_vld: got %b want 0", unit_vld); end
        arst_l = 1'b1;
        for (int c = 0; c < 5; c++) begin
            step;
            checks++; if (req_vec !== 4'h0 || advance !== 1'b0 || unit_vld !== 1'b0) begin
                errors++; $display("FAIL idle cyc%0d: req_vec=%b adv=%b uvld=%b want 0000/0/0", c, req_vec, advance, unit_vld);
            end
        end
    endtask

    task automatic test_single_post;
        logic [DW-1:0] d;
        d = 64'hDEAD_BEEF_0000_0002;
        do_reset;
        step;
        thr_req_vld = 4'b0100;
        thr_req_data[2*DW +: DW] = d;
        #1;
        checks++; if (req_vec !== 4'h0) begin errors++; $display("FAIL single T req_vec: got %b want 0000", req_vec); end
        step; thr_req_vld = 4'b0000; #1;
        checks++; if (req_vec !== 4'b0100) begin errors++; $display("FAIL single T+1 req_vec: got %b want 0100", req_vec); end
        checks++; if (advance !== 1'b1) begin errors++; $display("FAIL single T+1 advance: got %b want 1", advance); end
        checks++; if (unit_vld !== 1'b0) begin errors++; $display("FAIL single T+1 unit_vld: got %b want 0", unit_vld); end
        step;
        checks++; if (unit_vld !== 1'b1 || unit_tid !== 2'd2) begin errors++; $display("FAIL single T+2 launch: vld=%b tid=%0d want 1/2", unit_vld, unit_tid); end
        checks++; if (unit_data !== d) begin errors++; $display("FAIL single T+2 data: got %h want %h", unit_data, d); end
        checks++; if (req_vec !== 4'h0) begin errors++; $display("FAIL single T+2 req_vec: got %b want 0000", req_vec); end
        step; unit_rdy = 1'b1; #1;
        checks++; if (thr_req_rdy !== 4'b1011) begin errors++; $display("FAIL single T+3 rdy: got %b want 1011", thr_req_rdy); end
        step; unit_rdy = 1'b0;
        checks++; if (thr_req_rdy !== 4'hf || unit_vld !== 1'b0) begin errors++; $display("FAIL single T+4 rdy/vld: got %b/%b want 1111/0", thr_req_rdy, unit_vld); end
        step;
        step; unit_done = 1'b1;
        checks++; if (thr_done !== 4'h0) begin errors++; $display("FAIL single T+6 thr_done: got %b want 0000", thr_done); end
        step; unit_done = 1'b0;
        checks++; if (thr_done !== 4'b0100) begin errors++; $display("FAIL single T+7 thr_done: got %b want 0100", thr_done); end
        step;
        checks++; if (thr_done !== 4'h0) begin errors++; $display("FAIL single T+8 thr_done: got %b want 0000", thr_done); end
    endtask

    task automatic test_back_to_back;
        int launches;
        int cd;
        int last;
        launches = 0; cd = 0; last = 0;
        do_reset;
        for (int t = 0; t < 4; t++) thr_req_data[t*DW +: DW] = pay(t);
        step;
        thr_req_vld = 4'hf;
        for (int cyc = 0; cyc < 200 && launches < 8; cyc++) begin
            step;
            thr_req_vld = 4'b0000; unit_done = 1'b0; unit_rdy = 1'b0;
            if (thr_done !== 4'h0) begin
                checks++; if (thr_done !== (4'b0001 << last)) begin errors++; $display("FAIL b2b thr_done: got %b want tid %0d", thr_done, last); end
                thr_req_vld = thr_done;
            end
            if (cd > 0) begin
                cd--;
                if (cd == 0) unit_done = 1'b1;
            end
            if (unit_vld === 1'b1) begin
                checks++; if (unit_tid !== 2'(launches % 4)) begin errors++; $display("FAIL b2b order #%0d: tid %0d want %0d", launches, unit_tid, launches % 4); end
                checks++; if (unit_data !== pay(launches % 4)) begin errors++; $display("FAIL b2b data #%0d: got %h want %h", launches, unit_data, pay(launches % 4)); end
                last = launches % 4;
                unit_rdy = 1'b1;
                cd = 2;
                launches++;
            end
        end
        checks++; if (launches != 8) begin errors++; $display("FAIL b2b launches: got %0d want 8", launches); end
        step;
        unit_rdy = 1'b0;
    endtask

    task automatic test_issue_stall;
        logic [DW-1:0] d;
        d = 64'h0123_4567_89AB_CDEF;
        do_reset;
        step;
        thr_req_vld = 4'b0010;
        thr_req_data[1*DW +: DW] = d;
        step; thr_req_vld = 4'b0000;
        step;
        thr_req_vld = 4'b1000;  // thr 3 posts during ISSUE; must not be requested
        thr_req_data[3*DW +: DW] = pay(3);
        for (int c = 0; c < 5; c++) begin
            if (c > 0) begin step; thr_req_vld = 4'b0000; end
            #1;
            checks++; if (unit_vld !== 1'b1 || unit_tid !== 2'd1 || unit_data !== d || req_vec !== 4'h0 || advance !== 1'b0) begin
                errors++; $display("FAIL stall cyc%0d: vld=%b tid=%0d data=%h req=%b adv=%b", c, unit_vld, unit_tid, unit_data, req_vec, advance);
            end
        end
        step; unit_rdy = 1'b1;
        step; unit_rdy = 1'b0;
        checks++; if (unit_vld !== 1'b0 || thr_req_rdy !== 4'b0111) begin errors++; $display("FAIL stall busy: vld=%b rdy=%b want 0/0111", unit_vld, thr_req_rdy); end
    endtask

    task automatic test_flush;
        bit launched;
        launched = 1'b0;
        do_reset;
        step;
        thr_req_vld = 4'b1000;
        thr_req_data[3*DW +: DW] = pay(3);
        step; thr_req_vld = 4'b0000;
        step;
        thr_flush = 4'b1000;
        checks++; if (unit_vld !== 1'b1 || unit_tid !== 2'd3) begin errors++; $display("FAIL flush issue: vld=%b tid=%0d want 1/3", unit_vld, unit_tid); end
        step; thr_flush = 4'b0000; unit_rdy = 1'b1;
        checks++; if (thr_req_rdy !== 4'b0111) begin errors++; $display("FAIL flush committed: rdy=%b want 0111", thr_req_rdy); end
        step; unit_rdy = 1'b0;
        thr_req_vld = 4'b0010;
        thr_req_data[1*DW +: DW] = pay(1);
        step; thr_req_vld = 4'b0000;
        checks++; if (thr_req_rdy !== 4'b1101) begin errors++; $display("FAIL flush post1: rdy=%b want 1101", thr_req_rdy); end
        thr_flush = 4'b1010;
        step; thr_flush = 4'b0000;
        checks++; if (thr_req_rdy !== 4'hf) begin errors++; $display("FAIL flush cleared: rdy=%b want 1111", thr_req_rdy); end
        unit_done = 1'b1;
        step; unit_done = 1'b0;
        checks++; if (thr_done !== 4'b1000) begin errors++; $display("FAIL flush done3: got %b want 1000", thr_done); end
        for (int c = 0; c < 10; c++) begin
            step;
            if (unit_vld !== 1'b0 || req_vec !== 4'h0) launched = 1'b1;
        end
        checks++; if (launched) begin errors++; $display("FAIL flush thr1 launched: got 1 want 0"); end
        thr_req_vld = 4'b0001;
        thr_flush   = 4'b0001;
        thr_req_data[0 +: DW] = pay(0);
        step; thr_req_vld = 4'b0000; thr_flush = 4'b0000; #1;
        checks++; if (thr_req_rdy !== 4'b1110 || req_vec !== 4'b0001) begin errors++; $display("FAIL flush+post: rdy=%b req=%b want 1110/0001", thr_req_rdy, req_vec); end
    endtask

    task automatic test_reset_busy;
        do_reset;
        step;
        thr_req_vld = 4'b0100;
        thr_req_data[2*DW +: DW] = pay(2);
        step; thr_req_vld = 4'b0000;
        step; unit_rdy = 1'b1;
        thr_req_vld = 4'b0001;
        thr_req_data[0 +: DW] = pay(0);
        step; unit_rdy = 1'b0; thr_req_vld = 4'b0000;
        checks++; if (thr_req_rdy !== 4'b1110) begin errors++; $display("FAIL rstbusy pre: rdy=%b want 1110", thr_req_rdy); end
        arst_l = 1'b0;
        #1;
        checks++; if (thr_req_rdy !== 4'hf || req_vec !== 4'h0 || advance !== 1'b0 || unit_vld !== 1'b0 || thr_done !== 4'h0) begin
            errors++; $display("FAIL rstbusy outputs: rdy=%b req=%b adv=%b vld=%b done=%b", thr_req_rdy, req_vec, advance, unit_vld, thr_done);
        end
        #1; arst_l = 1'b1;
        step; unit_done = 1'b1;
        step; unit_done = 1'b0;
        checks++; if (thr_done !== 4'h0 || unit_vld !== 1'b0) begin errors++; $display("FAIL rstbusy late done: done=%b vld=%b want 0000/0", thr_done, unit_vld); end
        thr_req_vld = 4'b0010;
        thr_req_data[1*DW +: DW] = pay(1);
        step; thr_req_vld = 4'b0000; #1;
        checks++; if (req_vec !== 4'b0010 || advance !== 1'b1) begin errors++; $display("FAIL rstbusy repost req: req=%b adv=%b want 0010/1", req_vec, advance); end
        step;
        checks++; if (unit_vld !== 1'b1 || unit_tid !== 2'd1 || unit_data !== pay(1)) begin
            errors++; $display("FAIL rstbusy relaunch: vld=%b tid=%0d data=%h", unit_vld, unit_tid, unit_data);
        end
    endtask

    initial begin
        arst_l       = 1'b0;
        thr_req_vld  = 4'b0000;
        thr_req_data = '0;
        thr_flush    = 4'b0000;
        unit_rdy     = 1'b0;
        unit_done    = 1'b0;
        test_reset;
        test_single_post;
        test_back_to_back;
        test_issue_stall;
        test_flush;
        test_reset_busy;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
